// File: rtl/mux_arbiter_pkg.sv
// Shared types for the round-robin 2:1 mux arbiter.
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux_m.sv
// Plain 2:1 WIDTH-bit data mux shared by the two requesters.
module mux_m #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sel_a,
  output logic [WIDTH-1:0] out
);

  assign out = sel_a ? data_a : data_b;

endmodule

// File: rtl/mux_arbiter_m.sv
// Round-robin arbiter between requesters A and B feeding one registered,
// handshaked output stage through a shared 2:1 mux.
module mux_arbiter_m
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             valid_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ready_a,
  input  logic             valid_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready_b,
  output logic             sel_a,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             last_a_q;
  logic             grant_a_s;
  logic             grant_b_s;
  logic [WIDTH-1:0] mux_out;

  mux_m #(.WIDTH(WIDTH)) u_mux (
    .data_a (data_a),
    .data_b (data_b),
    .sel_a  (sel_a),
    .out    (mux_out)
  );

  // Grant, requester readies, mux select and next state.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    ready_a   = 1'b0;
    ready_b   = 1'b0;
    sel_a     = 1'b1;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        // Reset gates the grant so nothing is offered while rst_ is low.
        if (!rst_) begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end else if (valid_a && valid_b) begin
          grant_a_s = !last_a_q;
          grant_b_s = last_a_q;
        end else begin
          grant_a_s = valid_a;
          grant_b_s = valid_b;
        end
        ready_a = grant_a_s;
        ready_b = grant_b_s;
        sel_a   = grant_a_s || !grant_b_s;
        if (grant_a_s) begin
          state_d = SEND_A;
        end else if (grant_b_s) begin
          state_d = SEND_B;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_A, SEND_B: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, output word/valid and round-robin history.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      last_a_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (grant_a_s || grant_b_s)) begin
        out_q       <= mux_out;
        out_valid_q <= 1'b1;
        last_a_q    <= grant_a_s;
      end else if (state_q != IDLE && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
